ps2_frame_decoder: RTL and testbench
====================================

PS2_FRAME_DECODER -- requirements
Module: ps2_frame_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning consecutive identical clk samples needed to accept a new filtered PS/2 line level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000, meaning clk cycles without a filtered PS/2 clock falling edge before an in-progress frame is aborted (100 us at 100 MHz).
REQ-003 SHALL have port clk, input, 1, system clock; the only clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1, raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1, raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port code_valid, output, 1, one-cycle pulse when a complete key event is available.
REQ-008 SHALL have port code, output, 8, scan code of the last key event.
REQ-009 SHALL have port released, output, 1, last event was a break (F0-prefixed).
REQ-010 SHALL have port extended, output, 1, last event was E0-prefixed.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a two-flop synchronizer, then a deglitch filter; the filtered level changes only after FILTER_LEN consecutive equal synchronized samples.
REQ-013 SHALL sample filtered ps2_data on the clk cycle a filtered ps2_clk 1->0 transition is detected; no other cycle samples data.
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: a sampled 0 (start bit) -> DATA with bit counter = 0; a sampled 1 -> stay IDLE, no error.
REQ-016 DATA: shift 8 bits LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: record sampled bit -> STOP; frame parity is odd (8 data bits + parity bit contain an odd number of ones).
REQ-018 STOP: sampled 1 with correct parity = good byte; otherwise frame_err; either way -> IDLE.
REQ-019 Good byte 8'hE0 SHALL set the internal ext flag; 8'hF0 SHALL set the internal brk flag; neither pulses code_valid.
REQ-020 Any other good byte SHALL, on the clk cycle after the stop-bit sample, pulse code_valid and load code = byte, released = brk, extended = ext; ext and brk SHALL then clear.
REQ-021 code, released and extended SHALL hold their values until the next code_valid.
REQ-022 In DATA, PARITY or STOP, TIMEOUT_CYCLES clk cycles with no filtered falling edge SHALL return the FSM to IDLE, pulse frame_err and clear ext and brk; the timeout counter SHALL reset on every falling edge and in IDLE.
REQ-023 Any frame_err SHALL discard the partial byte and clear ext and brk; code/released/extended SHALL be unchanged.
REQ-024 code_valid and frame_err SHALL never assert in the same cycle; each is a single-cycle pulse.
REQ-025 Back-to-back frames with no idle gap SHALL be accepted: a start bit sampled on the first edge after STOP begins a new frame.

Reset
REQ-026 reset SHALL asynchronously force: FSM to IDLE, bit and timeout counters to 0, ext = brk = 0, code = 8'h00, released = extended = code_valid = frame_err = 0, synchronizer and filter state = 1 (idle line level).
REQ-027 reset asserted mid-frame SHALL drop the frame with no code_valid or frame_err pulse after deassertion; the next frame decodes normally.

Structure
REQ-028 The shared package snake_pkg SHALL hold the scan-code constants (KEY_UP 8'h75, KEY_DOWN 8'h72, KEY_LEFT 8'h6B, KEY_RIGHT 8'h74, PFX_EXT 8'hE0, PFX_BRK 8'hF0) and the FSM state encoding.
REQ-029 Synchronizer plus deglitch SHALL be one sub-module, ps2_line_filter, instantiated twice (clock line, data line).

Verification
REQ-030 Frame 0x75 (bits LSB first, parity 0, stop 1) preceded by E0 -> one code_valid, code = 8'h75, extended = 1, released = 0.
REQ-031 Sequence E0, F0, 6B -> one code_valid, code = 8'h6B, extended = 1, released = 1; a following 0x1C frame -> code = 8'h1C, extended = 0, released = 0.
REQ-032 Frame 0x74 with parity bit flipped -> frame_err pulse, no code_valid, code unchanged.
REQ-033 ps2_clk stopped after 4 data bits for TIMEOUT_CYCLES + 1 cycles -> exactly one frame_err pulse, FSM in IDLE; next good frame 0x72 -> code_valid, code = 8'h72.
REQ-034 Glitch of FILTER_LEN-1 cycles low on ps2_clk during a frame -> no extra bit sampled; frame decodes correctly.
REQ-035 reset pulsed after the 5th data bit of frame 0x75 -> no pulses; outputs at reset values; next frame 0x6B decodes with code = 8'h6B.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared scan-code constants and the PS/2 frame FSM state encoding.
package snake_pkg;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a deglitch filter for one PS/2 line.
// The filtered level only follows the input after FILTER_LEN equal samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;

    // Idle PS/2 lines float high, so every stage resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_decoder.sv
// PS/2 keyboard receiver: filters the lines, decodes 11-bit frames and folds
// E0/F0 prefixes into extended/released flags on the following key event.
module ps2_frame_decoder
    import snake_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       released,
    output logic       extended,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_f;
    logic data_f;
    logic clk_prev_reg;
    logic fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk),
        .level (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data),
        .level (data_f)
    );

    assign fall = clk_prev_reg & ~clk_f;

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic [TW-1:0] timeout_reg, timeout_next;
    logic          ext_reg, ext_next;
    logic          brk_reg, brk_next;
    logic [7:0]    code_next;
    logic          released_next, extended_next;
    logic          code_valid_next, frame_err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_prev_reg <= 1'b1;
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            timeout_reg  <= '0;
            ext_reg      <= 1'b0;
            brk_reg      <= 1'b0;
            code         <= 8'h00;
            released     <= 1'b0;
            extended     <= 1'b0;
            code_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            clk_prev_reg <= clk_f;
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            timeout_reg  <= timeout_next;
            ext_reg      <= ext_next;
            brk_reg      <= brk_next;
            code         <= code_next;
            released     <= released_next;
            extended     <= extended_next;
            code_valid   <= code_valid_next;
            frame_err    <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        timeout_next    = '0;
        ext_next        = ext_reg;
        brk_next        = brk_reg;
        code_next       = code;
        released_next   = released;
        extended_next   = extended;
        code_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        // Inside a frame, a stalled keyboard clock aborts after TIMEOUT_CYCLES.
        if (state_reg != IDLE && !fall) begin
            if (timeout_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next     = IDLE;
                frame_err_next = 1'b1;
                ext_next       = 1'b0;
                brk_next       = 1'b0;
            end else begin
                timeout_next = timeout_reg + 1'b1;
            end
        end

        if (fall) begin
            case (state_reg)
                IDLE: begin
                    if (!data_f) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next = {data_f, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    parity_next = data_f;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (data_f && (^{shift_reg, parity_reg})) begin
                        if (shift_reg == PFX_EXT) begin
                            ext_next = 1'b1;
                        end else if (shift_reg == PFX_BRK) begin
                            brk_next = 1'b1;
                        end else begin
                            code_valid_next = 1'b1;
                            code_next       = shift_reg;
                            released_next   = brk_reg;
                            extended_next   = ext_reg;
                            ext_next        = 1'b0;
                            brk_next        = 1'b0;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                        ext_next       = 1'b0;
                        brk_next       = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_decoder.sv
// Directed bench for ps2_frame_decoder: bit-banged PS/2 frames with
// hand-computed expectations, pulse counting on the falling clk edge.
module tb_ps2_frame_decoder;
    import snake_pkg::*;

    localparam int FL = 4;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       code_valid;
    logic [7:0] code;
    logic       released;
    logic       extended;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int cv_cnt = 0, fe_cnt = 0, both_cnt = 0, long_cnt = 0;
    logic cv_prev = 1'b0, fe_prev = 1'b0;

    ps2_frame_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_valid (code_valid),
        .code       (code),
        .released   (released),
        .extended   (extended),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
        if (code_valid && frame_err) both_cnt++;
        if (code_valid && cv_prev) long_cnt++;
        if (frame_err && fe_prev) long_cnt++;
        cv_prev = code_valid;
        fe_prev = frame_err;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        wait_clk(10);
        if (glitch) begin
            ps2_clk = 1'b0;
            wait_clk(FL - 1);
            ps2_clk = 1'b1;
            wait_clk(10);
        end
        ps2_clk = 1'b0;
        wait_clk(20);
        ps2_clk = 1'b1;
        wait_clk(10);
    endtask

    // nbits limits how many data bits are sent (for aborted frames).
    task automatic send_frame(input logic [7:0] b, input logic flip, input int glitch_idx,
                              input int nbits, input logic gap);
        logic par;
        par = ~(^b) ^ flip;
        send_bit(1'b0, glitch_idx == 0);
        for (int i = 0; i < nbits; i++) send_bit(b[i], glitch_idx == i + 1);
        if (nbits == 8) begin
            send_bit(par, glitch_idx == 9);
            send_bit(1'b1, glitch_idx == 10);
        end
        ps2_data = 1'b1;
        if (gap) wait_clk(20);
    endtask

    task automatic check_out(input string name, input int cv0, input int fe0, input int dcv,
                             input int dfe, input logic [7:0] c, input logic r, input logic e);
        total += 4;
        if ((cv_cnt - cv0) !== dcv) begin
            bad++;
            $display("FAIL %s code_valid pulses got=%0d want=%0d", name, cv_cnt - cv0, dcv);
        end
        if ((fe_cnt - fe0) !== dfe) begin
            bad++;
            $display("FAIL %s frame_err pulses got=%0d want=%0d", name, fe_cnt - fe0, dfe);
        end
        if (code !== c) begin
            bad++;
            $display("FAIL %s code got=%h want=%h", name, code, c);
        end
        if ({released, extended} !== {r, e}) begin
            bad++;
            $display("FAIL %s rel/ext got=%b%b want=%b%b", name, released, extended, r, e);
        end
        $display("%s: code=%h rel=%b ext=%b cv=%0d fe=%0d", name, code, released, extended,
                 cv_cnt - cv0, fe_cnt - fe0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_clk(5);
        check_out("reset_held", cv_cnt, fe_cnt, 0, 0, 8'h00, 1'b0, 1'b0);
        total++;
        if ({code_valid, frame_err} !== 2'b00) begin
            bad++;
            $display("FAIL reset_pulses got=%b want=00", {code_valid, frame_err});
        end
        reset = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_extended;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(PFX_EXT, 1'b0, -1, 8, 1'b1);
        send_frame(KEY_UP, 1'b0, -1, 8, 1'b1);
        check_out("ext_up", cv0, fe0, 1, 0, 8'h75, 1'b0, 1'b1);
    endtask

    task automatic test_break;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(PFX_EXT, 1'b0, -1, 8, 1'b1);
        send_frame(PFX_BRK, 1'b0, -1, 8, 1'b1);
        send_frame(KEY_LEFT, 1'b0, -1, 8, 1'b1);
        check_out("ext_brk_left", cv0, fe0, 1, 0, 8'h6B, 1'b1, 1'b1);
        cv0 = cv_cnt;
        send_frame(8'h1C, 1'b0, -1, 8, 1'b1);
        check_out("plain_1c", cv0, fe0, 1, 0, 8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_parity_err;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(PFX_EXT, 1'b0, -1, 8, 1'b1);
        send_frame(KEY_RIGHT, 1'b1, -1, 8, 1'b1);
        check_out("parity_err", cv0, fe0, 0, 1, 8'h1C, 1'b0, 1'b0);
        // The error must also have dropped the pending E0.
        cv0 = cv_cnt;
        send_frame(KEY_RIGHT, 1'b0, -1, 8, 1'b1);
        check_out("after_err", cv0, fe0, 1, 1, 8'h74, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(8'h5A, 1'b0, -1, 4, 1'b0);
        wait_clk(TO + 60);
        check_out("timeout", cv0, fe0, 0, 1, 8'h74, 1'b0, 1'b0);
        total++;
        if (dut.state_reg !== IDLE) begin
            bad++;
            $display("FAIL timeout_state got=%0d want=%0d", dut.state_reg, IDLE);
        end
        send_frame(KEY_DOWN, 1'b0, -1, 8, 1'b1);
        check_out("after_timeout", cv0, fe0, 1, 1, 8'h72, 1'b0, 1'b0);
    endtask

    task automatic test_glitch;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(8'h29, 1'b0, 4, 8, 1'b1);
        check_out("glitch", cv0, fe0, 1, 0, 8'h29, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(KEY_LEFT, 1'b0, -1, 8, 1'b0);
        send_frame(PFX_BRK, 1'b0, -1, 8, 1'b0);
        send_frame(KEY_RIGHT, 1'b0, -1, 8, 1'b1);
        check_out("back_to_back", cv0, fe0, 2, 0, 8'h74, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midframe;
        int cv0 = cv_cnt, fe0 = fe_cnt;
        send_frame(KEY_UP, 1'b0, -1, 5, 1'b0);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(TO + 60);
        check_out("reset_mid", cv0, fe0, 0, 0, 8'h00, 1'b0, 1'b0);
        send_frame(KEY_LEFT, 1'b0, -1, 8, 1'b1);
        check_out("after_reset", cv0, fe0, 1, 0, 8'h6B, 1'b0, 1'b0);
    endtask

    task automatic test_pulse_shape;
        total += 2;
        if (both_cnt !== 0) begin
            bad++;
            $display("FAIL overlap cycles got=%0d want=0", both_cnt);
        end
        if (long_cnt !== 0) begin
            bad++;
            $display("FAIL pulse_width extra cycles got=%0d want=0", long_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_extended;
        test_break;
        test_parity_err;
        test_timeout;
        test_glitch;
        test_back_to_back;
        test_reset_midframe;
        test_pulse_shape;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
